// File: rtl/pll_sup_pkg.sv
// pll_sup_pkg: shared types for the PLL lock supervisor.
// State encoding, counter widths and a small sizing helper.
package pll_sup_pkg;

  typedef enum logic [2:0] {
    RESET_PLL = 3'd0,
    WAIT_LOCK = 3'd1,
    STABILIZE = 3'd2,
    RUN       = 3'd3,
    FAULT     = 3'd4
  } pll_state_t;

  localparam int LOSS_CNT_W = 16;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/pll_sup_sync.sv
// pll_sup_sync: multi-flop single-bit synchronizer.
// Asynchronous active-low clear; reusable for any cross-domain level.
module pll_sup_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  // shift the async input through the flop chain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ff <= '0;
    else        ff <= {ff[STAGES-2:0], d};
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor: PLL reset sequencing, lock qualification, retry/fault.
// Optional lock-loss counter built only when PLL_SUP_LOSS_CNT_EN is defined.
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_TIMEOUT   = 50000,
  parameter int STABLE_CYCLES  = 1024,
  parameter int MAX_RETRIES    = 4,
  parameter int SYNC_STAGES    = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  pll_locked,
  input  logic                  clear_fault,
  output logic                  pll_rst,
  output logic                  out_reset_n,
  output logic                  fault,
  output logic [2:0]            state,
  output logic [2:0]            retry_cnt,
  output logic [LOSS_CNT_W-1:0] loss_count
);

  localparam int TMAX = max3(PLL_RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
  localparam int TW   = $clog2(TMAX + 1);

  localparam logic [TW-1:0] RST_LAST = TW'(PLL_RST_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(LOCK_TIMEOUT - 1);
  localparam logic [TW-1:0] STB_LAST = TW'(STABLE_CYCLES - 1);
  localparam logic [2:0]    MR       = 3'(MAX_RETRIES);

  pll_state_t    state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    retry_q, retry_d;
  logic          ors_q;
  logic          lk;

  pll_sup_sync #(
    .STAGES (SYNC_STAGES)
  ) u_lock_sync (
    .clk   (clk),
    .rst_n (reset_n),
    .d     (pll_locked),
    .q     (lk)
  );

  // state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= RESET_PLL;
    else          state_q <= state_d;
  end

  // next state and retry bookkeeping; lk=1 wins over a timeout
  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    case (state_q)
      RESET_PLL: begin
        if (timer_q == RST_LAST) state_d = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        if (lk) begin
          state_d = STABILIZE;
        end else if (timer_q == TO_LAST) begin
          retry_d = retry_q + 3'd1;
          state_d = (retry_q + 3'd1 == MR) ? FAULT : RESET_PLL;
        end
      end
      STABILIZE: begin
        if (!lk) begin
          state_d = WAIT_LOCK;
        end else if (timer_q == STB_LAST) begin
          state_d = RUN;
          retry_d = '0;
        end
      end
      RUN: begin
        if (!lk) state_d = WAIT_LOCK;
      end
      FAULT: begin
        if (clear_fault) begin
          state_d = RESET_PLL;
          retry_d = '0;
        end
      end
      default: state_d = RESET_PLL;
    endcase
  end

  // single shared timer, restarted on every state change
  always_comb begin
    timer_d = timer_q + TW'(1);
    if (state_d != state_q)                   timer_d = '0;
    else if (state_q == RUN || state_q == FAULT) timer_d = '0;
  end

  // timer, retry count and registered downstream reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      timer_q <= '0;
      retry_q <= '0;
      ors_q   <= 1'b0;
    end else begin
      timer_q <= timer_d;
      retry_q <= retry_d;
      ors_q   <= (state_d == RUN);
    end
  end

  // outputs decoded from the current state
  always_comb begin
    pll_rst = (state_q == RESET_PLL) || (state_q == FAULT);
    fault   = (state_q == FAULT);
  end

  assign out_reset_n = ors_q;
  assign state       = state_q;
  assign retry_cnt   = retry_q;

`ifdef PLL_SUP_LOSS_CNT_EN
  logic [LOSS_CNT_W-1:0] loss_q;

  // saturating count of lock drops seen while running
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      loss_q <= '0;
    end else if (state_q == RUN && !lk && loss_q != '1) begin
      loss_q <= loss_q + LOSS_CNT_W'(1);
    end
  end

  assign loss_count = loss_q;
`else
  assign loss_count = '0;
`endif

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// tb_pll_lock_supervisor: scenario tasks with an expected-value queue.
// Small timing parameters keep every scenario to a few dozen cycles.
module tb_pll_lock_supervisor;

  localparam int PRC = 4;
  localparam int LT  = 20;
  localparam int SC  = 8;
  localparam int MRT = 2;
  localparam int SS  = 2;

  logic        clk;
  logic        reset_n;
  logic        pll_locked;
  logic        clear_fault;
  logic        pll_rst;
  logic        out_reset_n;
  logic        fault;
  logic [2:0]  state;
  logic [2:0]  retry_cnt;
  logic [15:0] loss_count;

  typedef struct {
    string       name;
    logic [31:0] v;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] got[$];
  exp_t        e;
  logic [31:0] a;
  int          n_vec;
  int          n_err;

  pll_lock_supervisor #(
    .PLL_RST_CYCLES (PRC),
    .LOCK_TIMEOUT   (LT),
    .STABLE_CYCLES  (SC),
    .MAX_RETRIES    (MRT),
    .SYNC_STAGES    (SS)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .pll_locked  (pll_locked),
    .clear_fault (clear_fault),
    .pll_rst     (pll_rst),
    .out_reset_n (out_reset_n),
    .fault       (fault),
    .state       (state),
    .retry_cnt   (retry_cnt),
    .loss_count  (loss_count)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end

  task automatic do_reset();
    reset_n     = 1'b0;
    pll_locked  = 1'b0;
    clear_fault = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic wait_state(input logic [2:0] s);
    int n;
    n = 0;
    while (state !== s && n < 300) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset();
    reset_n     = 1'b0;
    pll_locked  = 1'b1;
    clear_fault = 1'b0;
    repeat (3) @(negedge clk);
    sb.push_back('{"rst_state", 0});
    sb.push_back('{"rst_pll_rst", 1});
    sb.push_back('{"rst_out_reset_n", 0});
    sb.push_back('{"rst_fault", 0});
    sb.push_back('{"rst_retry", 0});
    sb.push_back('{"rst_loss", 0});
    got.push_back(32'(state));
    got.push_back(32'(pll_rst));
    got.push_back(32'(out_reset_n));
    got.push_back(32'(fault));
    got.push_back(32'(retry_cnt));
    got.push_back(32'(loss_count));
    while (got.size() > 0) begin
      a = got.pop_front(); e = sb.pop_front(); n_vec++;
      if (a !== e.v) begin
        n_err++;
        $display("FAIL %s: got %0d want %0d", e.name, a, e.v);
      end
    end
  endtask

  task automatic test_bringup();
    int n;
    do_reset();
    sb.push_back('{"bringup_rst_len", PRC});
    n = 0;
    do begin @(negedge clk); n++; end
    while (pll_rst === 1'b1 && n < 50);
    got.push_back(32'(n));
    sb.push_back('{"bringup_wait_state", 1});
    got.push_back(32'(state));
    repeat (10 - PRC) @(negedge clk);
    pll_locked = 1'b1;
    sb.push_back('{"bringup_lock_lat", SS + SC + 1});
    n = 0;
    do begin @(negedge clk); n++; end
    while (out_reset_n !== 1'b1 && n < 100);
    got.push_back(32'(n));
    sb.push_back('{"bringup_state", 3});
    sb.push_back('{"bringup_retry", 0});
    sb.push_back('{"bringup_pll_rst", 0});
    got.push_back(32'(state));
    got.push_back(32'(retry_cnt));
    got.push_back(32'(pll_rst));
    while (got.size() > 0) begin
      a = got.pop_front(); e = sb.pop_front(); n_vec++;
      if (a !== e.v) begin
        n_err++;
        $display("FAIL %s: got %0d want %0d", e.name, a, e.v);
      end
    end
  endtask

  task automatic test_glitch();
    int n;
    int saw;
    do_reset();
    wait_state(3'd1);
    pll_locked = 1'b1;
    repeat (5) @(negedge clk);
    pll_locked = 1'b0;
    @(negedge clk);
    pll_locked = 1'b1;
    sb.push_back('{"glitch_back_to_wait", 1});
    sb.push_back('{"glitch_lat", SC + 3});
    n = 0;
    saw = 0;
    do begin
      @(negedge clk);
      n++;
      if (state === 3'd1) saw = 1;
    end while (out_reset_n !== 1'b1 && n < 100);
    got.push_back(32'(saw));
    got.push_back(32'(n));
    sb.push_back('{"glitch_retry", 0});
    sb.push_back('{"glitch_state", 3});
    got.push_back(32'(retry_cnt));
    got.push_back(32'(state));
    while (got.size() > 0) begin
      a = got.pop_front(); e = sb.pop_front(); n_vec++;
      if (a !== e.v) begin
        n_err++;
        $display("FAIL %s: got %0d want %0d", e.name, a, e.v);
      end
    end
  endtask

  task automatic test_timeout_boundary();
    do_reset();
    wait_state(3'd1);
    repeat (LT - SS - 1) @(negedge clk);
    pll_locked = 1'b1;
    repeat (SS + 1) @(negedge clk);
    sb.push_back('{"to_edge_state", 2});
    sb.push_back('{"to_edge_retry", 0});
    got.push_back(32'(state));
    got.push_back(32'(retry_cnt));
    while (got.size() > 0) begin
      a = got.pop_front(); e = sb.pop_front(); n_vec++;
      if (a !== e.v) begin
        n_err++;
        $display("FAIL %s: got %0d want %0d", e.name, a, e.v);
      end
    end
  endtask

  task automatic test_stable_boundary();
    do_reset();
    wait_state(3'd1);
    pll_locked = 1'b1;
    repeat (SC) @(negedge clk);
    pll_locked = 1'b0;
    repeat (3) @(negedge clk);
    sb.push_back('{"stb_edge_state", 1});
    sb.push_back('{"stb_edge_out_reset_n", 0});
    got.push_back(32'(state));
    got.push_back(32'(out_reset_n));
    while (got.size() > 0) begin
      a = got.pop_front(); e = sb.pop_front(); n_vec++;
      if (a !== e.v) begin
        n_err++;
        $display("FAIL %s: got %0d want %0d", e.name, a, e.v);
      end
    end
  endtask

  task automatic test_timeout_fault();
    int n;
    do_reset();
    sb.push_back('{"to1_cycles", PRC + LT});
    n = 0;
    do begin @(negedge clk); n++; end
    while (retry_cnt !== 3'd1 && n < 200);
    got.push_back(32'(n));
    sb.push_back('{"to1_state", 0});
    got.push_back(32'(state));
    sb.push_back('{"to2_cycles", PRC + LT});
    n = 0;
    do begin @(negedge clk); n++; end
    while (state !== 3'd4 && n < 200);
    got.push_back(32'(n));
    sb.push_back('{"fault_retry", 2});
    sb.push_back('{"fault_flag", 1});
    sb.push_back('{"fault_pll_rst", 1});
    sb.push_back('{"fault_out_reset_n", 0});
    got.push_back(32'(retry_cnt));
    got.push_back(32'(fault));
    got.push_back(32'(pll_rst));
    got.push_back(32'(out_reset_n));
    repeat (5) @(negedge clk);
    sb.push_back('{"fault_holds", 4});
    got.push_back(32'(state));
    while (got.size() > 0) begin
      a = got.pop_front(); e = sb.pop_front(); n_vec++;
      if (a !== e.v) begin
        n_err++;
        $display("FAIL %s: got %0d want %0d", e.name, a, e.v);
      end
    end
  endtask

  task automatic test_fault_clear();
    clear_fault = 1'b1;
    @(negedge clk);
    clear_fault = 1'b0;
    sb.push_back('{"clr_state", 0});
    sb.push_back('{"clr_retry", 0});
    sb.push_back('{"clr_fault", 0});
    sb.push_back('{"clr_pll_rst", 1});
    got.push_back(32'(state));
    got.push_back(32'(retry_cnt));
    got.push_back(32'(fault));
    got.push_back(32'(pll_rst));
    pll_locked = 1'b1;
    wait_state(3'd3);
    sb.push_back('{"clr_run_state", 3});
    sb.push_back('{"clr_run_out_reset_n", 1});
    got.push_back(32'(state));
    got.push_back(32'(out_reset_n));
    clear_fault = 1'b1;
    @(negedge clk);
    clear_fault = 1'b0;
    sb.push_back('{"clr_ignored_state", 3});
    sb.push_back('{"clr_ignored_retry", 0});
    got.push_back(32'(state));
    got.push_back(32'(retry_cnt));
    while (got.size() > 0) begin
      a = got.pop_front(); e = sb.pop_front(); n_vec++;
      if (a !== e.v) begin
        n_err++;
        $display("FAIL %s: got %0d want %0d", e.name, a, e.v);
      end
    end
  endtask

  task automatic test_loss();
    int n;
    do_reset();
    pll_locked = 1'b1;
    wait_state(3'd3);
    for (int i = 0; i < 3; i++) begin
      pll_locked = 1'b0;
      sb.push_back('{"drop_lat", SS + 1});
      n = 0;
      do begin @(negedge clk); n++; end
      while (out_reset_n !== 1'b0 && n < 50);
      got.push_back(32'(n));
      pll_locked = 1'b1;
      wait_state(3'd3);
    end
`ifdef PLL_SUP_LOSS_CNT_EN
    sb.push_back('{"loss_count", 3});
`else
    sb.push_back('{"loss_count", 0});
`endif
    sb.push_back('{"loss_relock", 1});
    got.push_back(32'(loss_count));
    got.push_back(32'(out_reset_n));
    while (got.size() > 0) begin
      a = got.pop_front(); e = sb.pop_front(); n_vec++;
      if (a !== e.v) begin
        n_err++;
        $display("FAIL %s: got %0d want %0d", e.name, a, e.v);
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    pll_locked = 1'b1;
    wait_state(3'd2);
    #3;
    reset_n = 1'b0;
    #1;
    sb.push_back('{"arst_stb_state", 0});
    sb.push_back('{"arst_stb_pll_rst", 1});
    sb.push_back('{"arst_stb_out_reset_n", 0});
    got.push_back(32'(state));
    got.push_back(32'(pll_rst));
    got.push_back(32'(out_reset_n));
    do_reset();
    pll_locked = 1'b1;
    wait_state(3'd3);
    #3;
    reset_n = 1'b0;
    #1;
    sb.push_back('{"arst_run_out_reset_n", 0});
    sb.push_back('{"arst_run_state", 0});
    got.push_back(32'(out_reset_n));
    got.push_back(32'(state));
    while (got.size() > 0) begin
      a = got.pop_front(); e = sb.pop_front(); n_vec++;
      if (a !== e.v) begin
        n_err++;
        $display("FAIL %s: got %0d want %0d", e.name, a, e.v);
      end
    end
  endtask

  initial begin
    n_vec       = 0;
    n_err       = 0;
    reset_n     = 1'b0;
    pll_locked  = 1'b0;
    clear_fault = 1'b0;
    test_reset();
    test_bringup();
    test_glitch();
    test_timeout_boundary();
    test_stable_boundary();
    test_timeout_fault();
    test_fault_clear();
    test_loss();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
